// File: rtl/acc_sequencer.sv
// acc_sequencer: sequences the column-reduction accumulator behind the
// systolic array. For every output word it clears the adder chain, admits
// k_len partial-sum beats, waits PIPE_LAT cycles for the reduction pipeline
// to drain, then strobes one store at the current output address.
//
// All outputs come straight from flops. Each output register is loaded with
// the decode of the state being entered. An output therefore changes in the
// same cycle as the state it belongs to, and no input reaches an output
// through combinational logic.

module acc_sequencer #(
    parameter int ARR_SIZE = 4,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = ARR_SIZE + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  k_len,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic              obuf_full,
    output logic              acc_reset,
    output logic              store_output,
    output logic [ADDR_W-1:0] op_buffer_address,
    output logic              busy,
    output logic              done
);

    localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DR_W-1:0] DRAIN_LAST = DR_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  k_q;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  beat_q;
    logic [DR_W-1:0]   drain_q;

    logic              psum_ready_q;
    logic              acc_reset_q;
    logic              store_q;
    logic              busy_q;
    logic              done_q;

    // Sequencer FSM with its counters and registered Moore outputs.
    // NOTE: every flop here is updated with <= so all of them see the
    // pre-edge values, which keeps the outputs and the state in step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            last_q       <= '0;
            addr_q       <= '0;
            beat_q       <= '0;
            drain_q      <= '0;
            psum_ready_q <= 1'b0;
            acc_reset_q  <= 1'b0;
            store_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // The pulse outputs are low unless the transition below raises them.
            acc_reset_q <= 1'b0;
            store_q     <= 1'b0;
            done_q      <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        k_q         <= (k_len == '0) ? CNT_W'(1) : k_len;
                        last_q      <= last_addr;
                        addr_q      <= '0;
                        state_q     <= S_CLEAR;
                        acc_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    beat_q       <= '0;
                    state_q      <= S_ACCUM;
                    psum_ready_q <= 1'b1;
                end

                S_ACCUM: begin
                    if (psum_valid && psum_ready_q) begin
                        beat_q <= beat_q + CNT_W'(1);
                        if (beat_q == k_q - CNT_W'(1)) begin
                            state_q      <= S_DRAIN;
                            psum_ready_q <= 1'b0;
                            drain_q      <= '0;
                        end
                    end
                end

                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_STORE;
                        // The strobe goes out on the first STORE cycle only if
                        // the buffer had room when this edge sampled obuf_full.
                        store_q <= !obuf_full;
                    end else begin
                        drain_q <= drain_q + DR_W'(1);
                    end
                end

                S_STORE: begin
                    if (store_q) begin
                        // The strobe was issued this cycle, so the word is written.
                        if (addr_q == last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q      <= addr_q + ADDR_W'(1);
                            state_q     <= S_CLEAR;
                            acc_reset_q <= 1'b1;
                        end
                    end else begin
                        store_q <= !obuf_full;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                end

                default: begin
                    state_q      <= S_IDLE;
                    busy_q       <= 1'b0;
                    psum_ready_q <= 1'b0;
                    addr_q       <= '0;
                end
            endcase

            // Cancel overrides everything. It clears the adder chain on the
            // way out and leaves no store or done pulse behind.
            if (abort && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                acc_reset_q  <= 1'b1;
                psum_ready_q <= 1'b0;
                store_q      <= 1'b0;
                done_q       <= 1'b0;
                busy_q       <= 1'b0;
                addr_q       <= '0;
            end
        end
    end

    assign psum_ready        = psum_ready_q;
    assign acc_reset         = acc_reset_q;
    assign store_output      = store_q;
    assign op_buffer_address = addr_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer. A negedge monitor logs the cycle of every
// pulse and handshake relative to the job start. Cycle 1 is the state entered
// on the edge that samples start. Each test task compares those logs against
// hand-computed schedules. Default parameters give PIPE_LAT = 5.

module tb_acc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] k_len = '0;
    logic [3:0] last_addr = '0;
    logic       psum_valid = 1'b0;
    logic       psum_ready;
    logic       obuf_full = 1'b0;
    logic       acc_reset;
    logic       store_output;
    logic [3:0] op_buffer_address;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int t0  = 0;
    int rel;

    int         hs_cyc[$];
    int         ar_cyc[$];
    int         st_cyc[$];
    logic [3:0] st_adr[$];
    int         dn_cyc[$];
    int         rdy_cnt;

    acc_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .k_len             (k_len),
        .last_addr         (last_addr),
        .psum_valid        (psum_valid),
        .psum_ready        (psum_ready),
        .obuf_full         (obuf_full),
        .acc_reset         (acc_reset),
        .store_output      (store_output),
        .op_buffer_address (op_buffer_address),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampling mid-cycle.
    always @(negedge clk) begin
        rel = cyc - t0;
        if (psum_valid && psum_ready) hs_cyc.push_back(rel);
        if (psum_ready) rdy_cnt++;
        if (acc_reset) ar_cyc.push_back(rel);
        if (store_output) begin
            st_cyc.push_back(rel);
            st_adr.push_back(op_buffer_address);
        end
        if (done) dn_cyc.push_back(rel);
    end

    task automatic clear_log();
        hs_cyc.delete();
        ar_cyc.delete();
        st_cyc.delete();
        st_adr.delete();
        dn_cyc.delete();
        rdy_cnt = 0;
    endtask

    // Call 1 time unit after a rising edge; returns 1 time unit into cycle 1.
    task automatic start_job(input logic [7:0] k, input logic [3:0] la);
        clear_log();
        k_len     = k;
        last_addr = la;
        start     = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc - 1;
        start = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({psum_ready, acc_reset, store_output, busy, done, op_buffer_address} !== 9'h000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=000",
                     {psum_ready, acc_reset, store_output, busy, done, op_buffer_address});
        end
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_single_word();
        psum_valid = 1'b1;
        obuf_full  = 1'b0;
        start_job(8'd3, 4'd0);
        for (int c = 1; c <= 14; c++) step();
        checks++;
        if (ar_cyc.size() != 1 || ar_cyc[0] != 1) begin
            errors++;
            $display("FAIL single_acc_reset got n=%0d first=%0d exp n=1 cyc=1", ar_cyc.size(), ar_cyc[0]);
        end
        checks++;
        if (hs_cyc.size() != 3 || hs_cyc[0] != 2 || hs_cyc[2] != 4) begin
            errors++;
            $display("FAIL single_handshakes got n=%0d first=%0d exp n=3 cyc 2..4", hs_cyc.size(), hs_cyc[0]);
        end
        checks++;
        if (st_cyc.size() != 1 || st_cyc[0] != 10 || st_adr[0] !== 4'd0) begin
            errors++;
            $display("FAIL single_store got n=%0d cyc=%0d addr=%0d exp n=1 cyc=10 addr=0",
                     st_cyc.size(), st_cyc[0], st_adr[0]);
        end
        checks++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != 11) begin
            errors++;
            $display("FAIL single_done got n=%0d cyc=%0d exp n=1 cyc=11", dn_cyc.size(), dn_cyc[0]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_multi_word_stall();
        psum_valid = 1'b1;
        start_job(8'd2, 4'd2);
        for (int c = 1; c <= 34; c++) begin
            obuf_full = (c >= 17 && c <= 19);
            step();
        end
        obuf_full = 1'b0;
        checks++;
        if (st_cyc.size() != 3) begin
            errors++;
            $display("FAIL multi_store_count got=%0d exp=3", st_cyc.size());
        end else begin
            checks++;
            if (st_cyc[0] != 9 || st_cyc[1] != 21 || st_cyc[2] != 30) begin
                errors++;
                $display("FAIL multi_store_cycles got=%0d,%0d,%0d exp=9,21,30", st_cyc[0], st_cyc[1], st_cyc[2]);
            end
            checks++;
            if (st_adr[0] !== 4'd0 || st_adr[1] !== 4'd1 || st_adr[2] !== 4'd2) begin
                errors++;
                $display("FAIL multi_store_addrs got=%0d,%0d,%0d exp=0,1,2", st_adr[0], st_adr[1], st_adr[2]);
            end
        end
        checks++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != 31) begin
            errors++;
            $display("FAIL multi_done got n=%0d cyc=%0d exp n=1 cyc=31", dn_cyc.size(), dn_cyc[0]);
        end
        checks++;
        if (hs_cyc.size() != 6) begin
            errors++;
            $display("FAIL multi_handshakes got=%0d exp=6", hs_cyc.size());
        end
    endtask

    task automatic test_k_zero();
        psum_valid = 1'b1;
        start_job(8'd0, 4'd1);
        for (int c = 1; c <= 20; c++) step();
        checks++;
        if (hs_cyc.size() != 2 || hs_cyc[0] != 2 || hs_cyc[1] != 10) begin
            errors++;
            $display("FAIL kzero_handshakes got n=%0d first=%0d exp n=2 cyc 2,10", hs_cyc.size(), hs_cyc[0]);
        end
        checks++;
        if (st_cyc.size() != 2 || st_cyc[0] != 8 || st_cyc[1] != 16 || st_adr[1] !== 4'd1) begin
            errors++;
            $display("FAIL kzero_stores got n=%0d first=%0d exp n=2 cyc 8,16", st_cyc.size(), st_cyc[0]);
        end
        checks++;
        if (dn_cyc.size() != 1 || dn_cyc[0] != 17) begin
            errors++;
            $display("FAIL kzero_done got n=%0d cyc=%0d exp n=1 cyc=17", dn_cyc.size(), dn_cyc[0]);
        end
    endtask

    task automatic test_valid_toggle();
        psum_valid = 1'b1;
        start_job(8'd2, 4'd0);
        for (int c = 1; c <= 14; c++) begin
            // Valid pattern 1,0,1,0 across cycles 2..5, then held high in DRAIN.
            psum_valid = !(c == 3 || c == 5);
            step();
        end
        psum_valid = 1'b1;
        checks++;
        if (hs_cyc.size() != 2 || hs_cyc[0] != 2 || hs_cyc[1] != 4) begin
            errors++;
            $display("FAIL toggle_handshakes got n=%0d first=%0d exp n=2 cyc 2,4", hs_cyc.size(), hs_cyc[0]);
        end
        checks++;
        if (rdy_cnt != 3) begin
            errors++;
            $display("FAIL toggle_ready_cycles got=%0d exp=3", rdy_cnt);
        end
        checks++;
        if (st_cyc.size() != 1 || st_cyc[0] != 10 || dn_cyc.size() != 1 || dn_cyc[0] != 11) begin
            errors++;
            $display("FAIL toggle_store_done got store n=%0d cyc=%0d exp n=1 cyc=10 done 11",
                     st_cyc.size(), st_cyc[0]);
        end
    endtask

    task automatic test_abort();
        psum_valid = 1'b1;
        start_job(8'd3, 4'd3);
        for (int c = 1; c <= 40; c++) begin
            abort = (c == 16);
            step();
        end
        abort = 1'b0;
        checks++;
        if (ar_cyc.size() != 3 || ar_cyc[1] != 11 || ar_cyc[2] != 17) begin
            errors++;
            $display("FAIL abort_acc_reset got n=%0d last=%0d exp n=3 cyc 1,11,17", ar_cyc.size(), ar_cyc[2]);
        end
        checks++;
        if (st_cyc.size() != 1 || st_cyc[0] != 10) begin
            errors++;
            $display("FAIL abort_stores got n=%0d exp n=1 cyc=10", st_cyc.size());
        end
        checks++;
        if (dn_cyc.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_busy got done n=%0d busy=%b exp 0 0", dn_cyc.size(), busy);
        end
        // Clean restart after the cancel.
        start_job(8'd1, 4'd0);
        for (int c = 1; c <= 12; c++) step();
        checks++;
        if (st_cyc.size() != 1 || st_cyc[0] != 8 || st_adr[0] !== 4'd0 || dn_cyc.size() != 1 || dn_cyc[0] != 9) begin
            errors++;
            $display("FAIL abort_restart got store n=%0d cyc=%0d addr=%0d exp n=1 cyc=8 addr=0 done 9",
                     st_cyc.size(), st_cyc[0], st_adr[0]);
        end
    endtask

    task automatic test_start_abort_idle();
        clear_log();
        start = 1'b1;
        abort = 1'b1;
        k_len = 8'd1;
        last_addr = 4'd0;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 12; c++) step();
        checks++;
        if (busy !== 1'b0 || ar_cyc.size() != 0 || st_cyc.size() != 0) begin
            errors++;
            $display("FAIL start_abort_idle got busy=%b resets=%0d stores=%0d exp 0 0 0",
                     busy, ar_cyc.size(), st_cyc.size());
        end
    endtask

    task automatic test_reset_mid_accum();
        psum_valid = 1'b0;
        start_job(8'd3, 4'd2);
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || psum_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_accum got busy=%b ready=%b exp 1 1", busy, psum_ready);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({psum_ready, acc_reset, store_output, busy, done, op_buffer_address} !== 9'h000) begin
            errors++;
            $display("FAIL async_reset_outputs got=%h exp=000",
                     {psum_ready, acc_reset, store_output, busy, done, op_buffer_address});
        end
        step();
        #2 rst = 1'b1;
        clear_log();
        psum_valid = 1'b1;
        step();
        for (int c = 0; c < 15; c++) step();
        checks++;
        if (busy !== 1'b0 || hs_cyc.size() != 0 || st_cyc.size() != 0 || ar_cyc.size() != 0) begin
            errors++;
            $display("FAIL post_reset_idle got busy=%b hs=%0d stores=%0d exp 0 0 0",
                     busy, hs_cyc.size(), st_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word_stall();
        test_k_zero();
        test_valid_toggle();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_accum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
